// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-input round-robin arbitrated mux with valid/ready on every
// channel and a one-deep registered output stage.
// Optional feature macro: RR_ARB_MUX_LOCK_EN (packet lock using in_last/out_last).
module rr_arb_mux #(
    parameter int WIDTH      = 8,
    parameter int NUM_INPUTS = 4,
    parameter int SEL_W      = $clog2(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] in_valid,
    input  logic [WIDTH-1:0]      in_data [NUM_INPUTS-1:0],
    output logic [NUM_INPUTS-1:0] in_ready,
`ifdef RR_ARB_MUX_LOCK_EN
    input  logic [NUM_INPUTS-1:0] in_last,
    output logic                  out_last,
`endif
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    input  logic                  out_ready
);

    logic                  r_out_valid;
    logic [WIDTH-1:0]      r_out_data;
    logic [SEL_W-1:0]      r_out_sel;
    logic [SEL_W-1:0]      r_ptr;

    logic                  w_load;
    logic                  w_any;
    logic [SEL_W-1:0]      w_idx;
    logic [NUM_INPUTS-1:0] w_gnt;
    logic [SEL_W-1:0]      w_ptr_nxt;

`ifdef RR_ARB_MUX_LOCK_EN
    logic                  r_locked;
    logic [SEL_W-1:0]      r_lock_sel;
    logic                  r_out_last;
`endif

    // Fold ptr+offset back into 0..NUM_INPUTS-1 without relying on a power-of-two width.
    function automatic logic [SEL_W-1:0] f_wrap(input int v);
        return SEL_W'((v >= NUM_INPUTS) ? (v - NUM_INPUTS) : v);
    endfunction

    assign w_load = !r_out_valid | out_ready;

    // First valid channel at or after the priority pointer; a held lock overrides the scan.
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (!w_any && in_valid[f_wrap(int'(r_ptr) + k)]) begin
                w_any = 1'b1;
                w_idx = f_wrap(int'(r_ptr) + k);
            end
        end
`ifdef RR_ARB_MUX_LOCK_EN
        if (r_locked) begin
            w_any = in_valid[r_lock_sel];
            w_idx = r_lock_sel;
        end
`endif
    end

    // One-hot grant; ready is suppressed while stalled or in reset.
    always_comb begin
        w_gnt = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_gnt[i] = w_any & (w_idx == SEL_W'(i));
        end
        in_ready = (reset | !w_load) ? '0 : w_gnt;
    end

    assign w_ptr_nxt = (w_idx == SEL_W'(NUM_INPUTS - 1)) ? '0 : w_idx + SEL_W'(1);

    // Output register and arbitration state: load on transfer, drain when idle, hold on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
            r_locked    <= 1'b0;
            r_lock_sel  <= '0;
            r_out_last  <= 1'b0;
`endif
        end else if (w_load) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data[w_idx];
                r_out_sel   <= w_idx;
`ifdef RR_ARB_MUX_LOCK_EN
                r_out_last  <= in_last[w_idx];
                r_locked    <= !in_last[w_idx];
                r_lock_sel  <= w_idx;
                // Rotation only moves on once the packet is complete.
                if (in_last[w_idx]) r_ptr <= w_ptr_nxt;
`else
                r_ptr       <= w_ptr_nxt;
`endif
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
`ifdef RR_ARB_MUX_LOCK_EN
    assign out_last  = r_out_last;
`endif

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

- Parametrised successor to the combinational `mux`: an N-input, WIDTH-bit round-robin arbitrated multiplexer with a valid/ready handshake on every input and on the output.
- The output is registered, with latency one cycle.
- Sits between several producer channels and one shared consumer, for example a shared bus or a shared FIFO write port.
- Replaces the externally driven `select` with internal fair arbitration, and reports the winning channel alongside the data.

## Interface
- `WIDTH`, 8: data bits per channel.
- `NUM_INPUTS`, 4: number of input channels. Legal values are ≥2; any value, not limited to powers of two.
- `SEL_W`, `$clog2(NUM_INPUTS)`: width of the channel index. Derived; never overridden.

Ports:
- `clk`, input, 1: the single clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `in_valid`, input, `NUM_INPUTS`: per-channel valid.
- `in_data`, input, `WIDTH` × `NUM_INPUTS` (unpacked array `[NUM_INPUTS-1:0]`): per-channel data.
- `in_ready`, output, `NUM_INPUTS`: per-channel ready. At most one bit is high.
- `out_valid`, output, 1: output register holds a beat.
- `out_data`, output, `WIDTH`: registered data.
- `out_sel`, output, `SEL_W`: index of the channel that supplied `out_data`.
- `out_ready`, input, 1: consumer accepts.
- `in_last`, input, `NUM_INPUTS`: packet-end markers. Present only with `RR_ARB_MUX_LOCK_EN`.
- `out_last`, output, 1: registered `in_last` of the winning channel. Present only with `RR_ARB_MUX_LOCK_EN`.

## Operation
- **Load condition:** `load = !out_valid | out_ready`. The output register accepts a new beat only when `load` is true.
- **Priority pointer:** `ptr`, `SEL_W` bits, value range 0..`NUM_INPUTS-1`.
- **Grant selection:** the grant goes to the first `i` with `in_valid[i]` set, scanning `ptr`, `ptr+1`, … and wrapping modulo `NUM_INPUTS`. The grant is combinational.
- **Ready:** `in_ready[i] = load & grant[i]`. A channel transfers on a cycle where `in_valid[i] & in_ready[i]`.
- **On a transfer:**
  - `out_data <= in_data[i]`, `out_sel <= i`, `out_valid <= 1`.
  - `ptr <= (i == NUM_INPUTS-1) ? 0 : i+1`. Wrap-around is explicit, so non-power-of-two `NUM_INPUTS` never produces an out-of-range pointer.
- **Drain without refill:** if `out_valid & out_ready` and no `in_valid` is set, then `out_valid <= 0`. `out_data` and `out_sel` hold their last values.
- **Stall:** if `out_valid & !out_ready`, all `in_ready` are 0 and the output register holds.
- **Pointer stability:** `ptr` changes only on a transfer.
- **Reset:** while `reset` is high, all of the following are 0 at the next edge and stay 0 while reset is held:
  - `out_valid`, `out_data`, `out_sel`, `ptr` (and lock state).
  - `in_ready` (forced low combinationally).
- **Reset during a stall:** the pending output beat is discarded. It is not replayed.

## Timing
- Latency is one cycle: a beat accepted at edge *n* is presented on `out_*` after edge *n*.
- Throughput is one beat per cycle while `out_ready` stays high. There is no bubble between back-to-back beats, from the same channel or from different channels.
- **Fairness:** with all channels continuously valid, grants rotate 0, 1, …, `NUM_INPUTS-1`, 0, … One grant per cycle.
- `in_ready` depends combinationally on `in_valid`, `out_valid` and `out_ready`. Producers must not make `in_valid` depend on `in_ready`.
- `out_valid`, `out_data`, `out_sel` and `out_last` come directly from flops.

## Configuration
- Macro: `RR_ARB_MUX_LOCK_EN`.
- **Defined:** packet lock.
  - Adds `in_last` and `out_last`.
  - After a transfer from channel `i` with `in_last[i] = 0`, the arbiter locks to `i`. Only `i` can be granted until a transfer with `in_last[i] = 1`, even if `in_valid[i]` drops for some cycles.
  - `ptr` advances only on the transfer that carries `last`.
  - Reset clears the lock.
- **Undefined:** no `last` ports; every beat is arbitrated independently as described above.

## Test plan
All scenarios use `WIDTH=8`, `NUM_INPUTS=4`, with `in_data` = {`8'h3a`, `8'h6b`, `8'hf3`, `8'h45`} for channels 0..3.

- **Reset:** hold `reset` for 2 cycles with all `in_valid = 4'hf`. Required: `out_valid = 0`, `out_data = 0`, `out_sel = 0`, `in_ready = 0` throughout.
- **Rotation:** `in_valid = 4'hf`, `out_ready = 1`, for 8 cycles. Required `out_sel` sequence 0,1,2,3,0,1,2,3 with `out_data` `3a`,`6b`,`f3`,`45` repeating, and `out_valid` continuously high.
- **Sparse requests and wrap:** `in_valid = 4'b1001` after a grant to channel 3. Required: next grant is channel 0 (`out_data = 8'h3a`), then channel 3 (`8'h45`).
- **Backpressure:** `out_ready = 0` for 3 cycles with `out_data = 8'h6b`. Required: `out_data` holds `8'h6b`, all `in_ready` stay 0, and `ptr` is unchanged. On release, the next beat is `8'hf3` from channel 2.
- **Reset mid-stall:** assert `reset` while `out_valid = 1` and `out_ready = 0`. Required: `out_valid = 0` after the edge. The first grant after reset is channel 0.
- **Lock (macro defined):** channel 1 sends 3 beats with `last` on the 3rd, while channels 0, 2 and 3 are valid. Required `out_sel` sequence 1,1,1,2; `out_last` is high only on the 3rd beat.
